// File: rtl/full_st0_error_buffer.sv
// Stage-0 error buffer: captures the accepted error stream into a 4-phase RAM and
// replays one full phase as a burst. Define FULL_ST0_ERRBUF_OREG_EN for an extra output register.
module full_st0_error_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] load_length,
  input  logic              error_valid,
  input  logic [DATA_W-1:0] error_value,
  input  logic [1:0]        error_phase,
  input  logic [ADDR_W-1:0] error_sub_address,
  input  logic              error_update_first,
  input  logic [1:0]        error_phase_read,
  output logic              tap_error_vld,
  output logic [DATA_W-1:0] tap_error,
  output logic              tap_error_first,
  output logic              tap_error_last,
  output logic [3:0]        phase_full,
  output logic              replay_busy,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int PH_W  = 2;
  localparam int IDX_W = PH_W + ADDR_W;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_READ
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     rd_phase_q, rd_phase_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [3:0]          full_q, full_d;
  logic [3:0]          set_mask, clr_mask;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic                rd_en;
  logic                rd_first;
  logic                rd_last;
  logic [PH_W-1:0]     rd_sel_phase;
  logic [ADDR_W-1:0]   rd_sel_addr;
  logic [IDX_W-1:0]    rd_idx;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                vld_p1_q;
  logic                first_p1_q;
  logic                last_p1_q;
  logic [DATA_W-1:0]   data_p1_q;

  // Write side: a full phase refuses every write until its replay drains it.
  always_comb begin
    wr_en    = error_valid && !full_q[error_phase];
    wr_idx   = {error_phase, error_sub_address};
    set_mask = '0;
    if (wr_en && (error_sub_address == load_length)) begin
      set_mask[error_phase] = 1'b1;
    end
    ovf_d = ovf_q || (error_valid && full_q[error_phase]);
  end

  // Set wins over clear on the same bit.
  assign full_d = (full_q & ~clr_mask) | set_mask;

  // The first read is issued on the accepting cycle, so data follows the pulse by one
  // cycle and a pulse on the first IDLE cycle after a burst continues it without a gap.
  always_comb begin
    state_d      = state_q;
    rd_phase_d   = rd_phase_q;
    rd_addr_d    = rd_addr_q;
    udf_d        = udf_q;
    clr_mask     = '0;
    rd_en        = 1'b0;
    rd_first     = 1'b0;
    rd_last      = 1'b0;
    rd_sel_phase = rd_phase_q;
    rd_sel_addr  = rd_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (error_update_first) begin
          if (full_q[error_phase_read]) begin
            rd_en        = 1'b1;
            rd_first     = 1'b1;
            rd_sel_phase = error_phase_read;
            rd_sel_addr  = '0;
            rd_phase_d   = error_phase_read;
            if (load_length == '0) begin
              rd_last                    = 1'b1;
              clr_mask[error_phase_read] = 1'b1;
              rd_addr_d                  = '0;
            end else begin
              rd_addr_d = ADDR_W'(1);
              state_d   = ST_READ;
            end
          end else begin
            udf_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        rd_en = 1'b1;
        if (rd_addr_q == load_length) begin
          rd_last              = 1'b1;
          clr_mask[rd_phase_q] = 1'b1;
          rd_addr_d            = '0;
          state_d              = ST_IDLE;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_idx = {rd_sel_phase, rd_sel_addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_phase_q <= '0;
      rd_addr_q  <= '0;
      full_q     <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_phase_q <= rd_phase_d;
      rd_addr_q  <= rd_addr_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= error_value;
    end
  end

  // ---- stage p1: synchronous RAM read register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      data_p1_q  <= '0;
    end else begin
      vld_p1_q   <= rd_en;
      first_p1_q <= rd_first;
      last_p1_q  <= rd_last;
      if (rd_en) begin
        data_p1_q <= mem_q[rd_idx];
      end
    end
  end

`ifdef FULL_ST0_ERRBUF_OREG_EN
  logic                vld_p2_q;
  logic                first_p2_q;
  logic                last_p2_q;
  logic [DATA_W-1:0]   data_p2_q;

  // ---- stage p2: optional output register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q   <= 1'b0;
      first_p2_q <= 1'b0;
      last_p2_q  <= 1'b0;
      data_p2_q  <= '0;
    end else begin
      vld_p2_q   <= vld_p1_q;
      first_p2_q <= first_p1_q;
      last_p2_q  <= last_p1_q;
      data_p2_q  <= data_p1_q;
    end
  end

  assign tap_error_vld   = vld_p2_q;
  assign tap_error_first = first_p2_q;
  assign tap_error_last  = last_p2_q;
  assign tap_error       = data_p2_q;
`else
  assign tap_error_vld   = vld_p1_q;
  assign tap_error_first = first_p1_q;
  assign tap_error_last  = last_p1_q;
  assign tap_error       = data_p1_q;
`endif

  assign phase_full    = full_q;
  assign replay_busy   = (state_q == ST_READ);
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

endmodule

// File: tb/tb_full_st0_error_buffer.sv
// Directed bench for full_st0_error_buffer: per-cycle vector table plus hand-written
// sequences for replay latency and reset in the middle of a burst.
module tb_full_st0_error_buffer;

  localparam int DW = 32;
  localparam int AW = 3;
`ifdef FULL_ST0_ERRBUF_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          reset;
  logic [AW-1:0] load_length;
  logic          error_valid;
  logic [DW-1:0] error_value;
  logic [1:0]    error_phase;
  logic [AW-1:0] error_sub_address;
  logic          error_update_first;
  logic [1:0]    error_phase_read;
  logic          tap_error_vld;
  logic [DW-1:0] tap_error;
  logic          tap_error_first;
  logic          tap_error_last;
  logic [3:0]    phase_full;
  logic          replay_busy;
  logic          overflow_err;
  logic          underflow_err;

  full_st0_error_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk                (clk),
    .reset              (reset),
    .load_length        (load_length),
    .error_valid        (error_valid),
    .error_value        (error_value),
    .error_phase        (error_phase),
    .error_sub_address  (error_sub_address),
    .error_update_first (error_update_first),
    .error_phase_read   (error_phase_read),
    .tap_error_vld      (tap_error_vld),
    .tap_error          (tap_error),
    .tap_error_first    (tap_error_first),
    .tap_error_last     (tap_error_last),
    .phase_full         (phase_full),
    .replay_busy        (replay_busy),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected tap fields describe the read issued in that row's cycle (latency 1).
  typedef struct {
    logic          rst;
    logic [AW-1:0] ll;
    logic          v;
    logic [1:0]    ph;
    logic [AW-1:0] sub;
    logic [DW-1:0] val;
    logic          upd;
    logic [1:0]    prd;
    logic          ev;
    logic [DW-1:0] ed;
    logic          ef;
    logic          el;
    logic [3:0]    efull;
    logic          ebusy;
    logic          eovf;
    logic          eudf;
  } vec_t;

  vec_t          vecs[$];
  logic [AW-1:0] b_ll;
  logic          b_ovf;
  logic          b_udf;
  int            n_tests;
  int            n_fail;

  localparam logic [DW-1:0] WA = 32'hA000_0000;
  localparam logic [DW-1:0] WB = 32'hB000_0010;
  localparam logic [DW-1:0] WC = 32'hC000_0020;
  localparam logic [DW-1:0] WD = 32'hD000_0030;
  localparam logic [DW-1:0] WF = 32'hF000_0040;
  localparam logic [DW-1:0] WE = 32'hE000_0050;

  task automatic add(input logic rst, input logic v, input logic [1:0] ph, input logic [AW-1:0] sub,
                     input logic [DW-1:0] val, input logic upd, input logic [1:0] prd,
                     input logic ev, input logic [DW-1:0] ed, input logic ef, input logic el,
                     input logic [3:0] efull, input logic ebusy);
    vec_t r;
    r.rst = rst; r.ll = b_ll; r.v = v; r.ph = ph; r.sub = sub; r.val = val;
    r.upd = upd; r.prd = prd; r.ev = ev; r.ed = ed; r.ef = ef; r.el = el;
    r.efull = efull; r.ebusy = ebusy; r.eovf = b_ovf; r.eudf = b_udf;
    vecs.push_back(r);
  endtask

  task automatic add_wr(input logic [1:0] ph, input int k, input logic [DW-1:0] val,
                        input logic [3:0] efull);
    add(1'b0, 1'b1, ph, AW'(k), val, 1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b0, efull, 1'b0);
  endtask

  task automatic add_idle(input logic [3:0] efull);
    add(1'b0, 1'b0, 2'd0, '0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b0, efull, 1'b0);
  endtask

  // Four-word replay (load_length=3) with an optional concurrent write stream to another phase.
  task automatic add_burst(input logic [1:0] prd, input logic [DW-1:0] base,
                           input logic [3:0] f_during, input logic [3:0] f_after,
                           input logic wv, input logic [1:0] wph, input logic [DW-1:0] wbase);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, wv, wph, AW'(k), wbase + DW'(k), (k == 0), prd,
          1'b1, base + DW'(k), (k == 0), (k == 3),
          (k == 3) ? f_after : f_during, (k != 3));
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic          tev, tef, tel, ok;
    logic [DW-1:0] ted;
    int            cyc;

    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; load_length = '0; error_valid = 1'b0; error_value = '0;
    error_phase = '0; error_sub_address = '0; error_update_first = 1'b0; error_phase_read = '0;

    b_ll = 3'd3; b_ovf = 1'b0; b_udf = 1'b0;
    add(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b0, 4'b0000, 1'b0);
    // Basic fill and replay of phase 0.
    for (int k = 0; k < 4; k++) add_wr(2'd0, k, WA + DW'(k), (k == 3) ? 4'b0001 : 4'b0000);
    add_burst(2'd0, WA, 4'b0001, 4'b0000, 1'b0, 2'd0, '0);
    add_idle(4'b0000);
    // Two full phases replayed back to back.
    for (int k = 0; k < 4; k++) add_wr(2'd0, k, WB + DW'(k), (k == 3) ? 4'b0001 : 4'b0000);
    for (int k = 0; k < 4; k++) add_wr(2'd1, k, WC + DW'(k), (k == 3) ? 4'b0011 : 4'b0001);
    add_burst(2'd0, WB, 4'b0011, 4'b0010, 1'b0, 2'd0, '0);
    add_burst(2'd1, WC, 4'b0010, 4'b0000, 1'b0, 2'd0, '0);
    add_idle(4'b0000);
    // Overflow into full phase 2, then replay it while phase 3 fills concurrently.
    for (int k = 0; k < 4; k++) add_wr(2'd2, k, WD + DW'(k), (k == 3) ? 4'b0100 : 4'b0000);
    b_ovf = 1'b1;
    add_wr(2'd2, 0, 32'hDEAD_BEEF, 4'b0100);
    add_burst(2'd2, WD, 4'b0100, 4'b1000, 1'b1, 2'd3, WF);
    add_burst(2'd3, WF, 4'b1000, 4'b0000, 1'b0, 2'd0, '0);
    add_idle(4'b0000);
    // Underflow on empty phase 3.
    b_udf = 1'b1;
    add(1'b0, 1'b0, 2'd0, '0, '0, 1'b1, 2'd3, 1'b0, '0, 1'b0, 1'b0, 4'b0000, 1'b0);
    add_idle(4'b0000);
    b_ovf = 1'b0; b_udf = 1'b0;
    add(1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b0, 1'b0, 4'b0000, 1'b0);
    // Single-entry phases.
    b_ll = 3'd0;
    add_wr(2'd1, 0, WE, 4'b0010);
    add(1'b0, 1'b0, 2'd0, '0, '0, 1'b1, 2'd1, 1'b1, WE, 1'b1, 1'b1, 4'b0000, 1'b0);
    add_idle(4'b0000);
    add_idle(4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset              = vecs[i].rst;
      load_length        = vecs[i].ll;
      error_valid        = vecs[i].v;
      error_phase        = vecs[i].ph;
      error_sub_address  = vecs[i].sub;
      error_value        = vecs[i].val;
      error_update_first = vecs[i].upd;
      error_phase_read   = vecs[i].prd;
      @(posedge clk);
      #1;
      tev = 1'b0; ted = '0; tef = 1'b0; tel = 1'b0;
      if (!vecs[i].rst) begin
        if (LAT == 1) begin
          tev = vecs[i].ev; ted = vecs[i].ed; tef = vecs[i].ef; tel = vecs[i].el;
        end else if (i > 0) begin
          tev = vecs[i-1].ev; ted = vecs[i-1].ed; tef = vecs[i-1].ef; tel = vecs[i-1].el;
        end
      end
      ok = (tap_error_vld === tev) && (phase_full === vecs[i].efull) &&
           (replay_busy === vecs[i].ebusy) && (overflow_err === vecs[i].eovf) &&
           (underflow_err === vecs[i].eudf);
      if (tev) ok = ok && (tap_error === ted) && (tap_error_first === tef) && (tap_error_last === tel);
      if (vecs[i].rst) ok = ok && (tap_error === '0) && !tap_error_first && !tap_error_last;
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL row%0d: got vld=%0b data=%h first=%0b last=%0b full=%b busy=%0b ovf=%0b udf=%0b; expected vld=%0b data=%h first=%0b last=%0b full=%b busy=%0b ovf=%0b udf=%0b",
                 i, tap_error_vld, tap_error, tap_error_first, tap_error_last, phase_full,
                 replay_busy, overflow_err, underflow_err, tev, ted, tef, tel,
                 vecs[i].efull, vecs[i].ebusy, vecs[i].eovf, vecs[i].eudf);
      end
    end

    // Hand sequence: pulse-to-data latency and word order.
    @(negedge clk);
    reset = 1'b1; load_length = 3'd3; error_valid = 1'b0; error_update_first = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      error_valid = 1'b1; error_phase = 2'd0; error_sub_address = AW'(k); error_value = WA + DW'(k);
    end
    @(negedge clk);
    error_valid = 1'b0;
    check("full_before_replay", 64'(phase_full), 64'h1);
    error_update_first = 1'b1; error_phase_read = 2'd0;
    @(posedge clk); #1;
    error_update_first = 1'b0;
    cyc = 1;
    while (!tap_error_vld && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("replay_latency", 64'(cyc), 64'(LAT));
    check("word0", {31'd0, tap_error_first, tap_error}, {31'd0, 1'b1, WA});
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      check("word_seq", {30'd0, tap_error_vld, tap_error_last, tap_error},
            {30'd0, 1'b1, (k == 3), WA + DW'(k)});
    end

    // Hand sequence: reset while the second word is on the output.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      error_valid = 1'b1; error_phase = 2'd0; error_sub_address = AW'(k); error_value = WB + DW'(k);
    end
    @(negedge clk);
    error_valid = 1'b0;
    error_update_first = 1'b1; error_phase_read = 2'd0;
    @(posedge clk); #1;
    error_update_first = 1'b0;
    cyc = 1;
    while (!tap_error_vld && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midburst_word0", {31'd0, tap_error_vld, tap_error}, {31'd0, 1'b1, WB});
    @(posedge clk); #1;
    check("midburst_word1", {31'd0, tap_error_vld, tap_error}, {31'd0, 1'b1, WB + 32'd1});
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_midburst", {58'd0, tap_error_vld, replay_busy, phase_full}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("after_reset_idle", {62'd0, tap_error_vld, replay_busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
